// File: rtl/msrv_32_buffered_store_unit_if.sv
// Data-memory bus bundle between the buffered store unit (master) and the
// AHB-style data memory (slave).
interface msrv_32_buffered_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                ahb_ready_in;
    logic [ADDR_W-1:0]   ms_riscv32_mp_dmaddr_out;
    logic [XLEN/8-1:0]   ms_riscv32_mp_dmwr_mask_out;
    logic [XLEN-1:0]     ms_riscv32_mp_dmdata_out;
    logic                ms_riscv32_mp_dmwr_req_out;
    logic [1:0]          ahb_htrans_out;

    modport master (
        input  ahb_ready_in,
        output ms_riscv32_mp_dmaddr_out,
        output ms_riscv32_mp_dmwr_mask_out,
        output ms_riscv32_mp_dmdata_out,
        output ms_riscv32_mp_dmwr_req_out,
        output ahb_htrans_out
    );

    modport slave (
        output ahb_ready_in,
        input  ms_riscv32_mp_dmaddr_out,
        input  ms_riscv32_mp_dmwr_mask_out,
        input  ms_riscv32_mp_dmdata_out,
        input  ms_riscv32_mp_dmwr_req_out,
        input  ahb_htrans_out
    );
endinterface

// File: rtl/msrv_32_buffered_store_unit.sv
// Store alignment, DEPTH-entry in-order store buffer and a two-phase
// (address/data) AHB-style drain engine with load-address hazard detection.
module msrv_32_buffered_store_unit #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     ms_riscv32_mp_clk_in,
    input  logic                     ms_riscv32_mp_rst_in,
    input  logic [1:0]               funct3_in,
    input  logic [ADDR_W-1:0]        iaddr_in,
    input  logic [XLEN-1:0]          rs2_in,
    input  logic                     mem_wr_req_in,
    output logic                     st_ready_out,
    output logic                     misaligned_out,
    input  logic [ADDR_W-1:0]        ld_addr_in,
    output logic                     ld_hazard_out,
    output logic [$clog2(DEPTH):0]   count_out,
    msrv_32_buffered_store_unit_if.master bus
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int PW  = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    function automatic logic [XLEN-1:0] align_data(input logic [1:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            2'b00:   align_data = {NB{d[7:0]}};
            2'b01:   align_data = {(NB/2){d[15:0]}};
            2'b10:   align_data = {(NB/4){d[31:0]}};
            default: align_data = d;
        endcase
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] f3, input logic [OFF-1:0] off);
        logic [NB-1:0] m;
        m = '0;
        case (f3)
            2'b00:   m[0]   = 1'b1;
            2'b01:   m[1:0] = 2'b11;
            2'b10:   m[3:0] = 4'hF;
            default: m      = '1;
        endcase
        lane_mask = m << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] f3, input logic [OFF-1:0] off);
        case (f3)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            2'b10:   is_misaligned = (off[1:0] != 2'b00);
            default: is_misaligned = (XLEN == 64) ? (off != '0) : 1'b1;
        endcase
    endfunction

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [NB-1:0]     mask_q [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count, count_nx;
    state_t            state, state_nx;
    logic              full, push, pop, bad;

    // full comes only from the count register, so st_ready never sees ahb_ready
    assign full           = (count == (PW+1)'(DEPTH));
    assign bad            = is_misaligned(funct3_in, iaddr_in[OFF-1:0]);
    assign misaligned_out = mem_wr_req_in && bad;
    assign push           = mem_wr_req_in && !bad && !full;
    assign pop            = (state == S_DATA) && bus.ahb_ready_in;
    assign st_ready_out   = !full;
    assign count_out      = count;

    always_comb begin
        count_nx = count;
        case ({push, pop})
            2'b10:   count_nx = count + (PW+1)'(1);
            2'b01:   count_nx = count - (PW+1)'(1);
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state <= S_IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (pop) begin
                head        <= head + PW'(1);
                valid[head] <= 1'b0;
            end
            if (push) begin
                tail        <= tail + PW'(1);
                valid[tail] <= 1'b1;
            end
        end
    end

    // Payload storage is qualified by valid, so it needs no reset
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            addr_q[tail] <= {iaddr_in[ADDR_W-1:OFF], {OFF{1'b0}}};
            mask_q[tail] <= lane_mask(funct3_in, iaddr_in[OFF-1:0]);
            data_q[tail] <= align_data(funct3_in, rs2_in);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (count_nx != '0) state_nx = S_ADDR;
            S_ADDR:  if (bus.ahb_ready_in) state_nx = S_DATA;
            S_DATA:  if (bus.ahb_ready_in) state_nx = (count_nx != '0) ? S_ADDR : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ms_riscv32_mp_dmaddr_out    = '0;
        bus.ms_riscv32_mp_dmwr_mask_out = '0;
        bus.ms_riscv32_mp_dmdata_out    = '0;
        bus.ms_riscv32_mp_dmwr_req_out  = 1'b0;
        bus.ahb_htrans_out              = 2'b00;
        case (state)
            S_ADDR: begin
                bus.ms_riscv32_mp_dmaddr_out    = addr_q[head];
                bus.ms_riscv32_mp_dmwr_mask_out = mask_q[head];
                bus.ms_riscv32_mp_dmwr_req_out  = 1'b1;
                bus.ahb_htrans_out              = 2'b10;
            end
            S_DATA: bus.ms_riscv32_mp_dmdata_out = data_q[head];
            default: ;
        endcase
    end

    // The in-flight head stays valid until its data phase completes
    always_comb begin
        ld_hazard_out = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (((ld_addr_in ^ addr_q[i]) >> OFF) == '0))
                ld_hazard_out = 1'b1;
        end
    end
endmodule

// File: tb/tb_msrv_32_buffered_store_unit.sv
// Bench for msrv_32_buffered_store_unit: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_msrv_32_buffered_store_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  f3 = '0;
    logic [31:0] addr = '0, rs2 = '0, ld_addr = '0;
    logic        req = 1'b0;
    logic        st_ready, mis, hz;
    logic [2:0]  count;

    logic [1:0]  f3_64 = '0;
    logic [31:0] addr_64 = '0, ld_addr_64 = '0;
    logic [63:0] rs2_64 = '0;
    logic        req_64 = 1'b0;
    logic        st_ready_64, mis_64, hz_64;
    logic [2:0]  count_64;

    msrv_32_buffered_store_unit_if #(.XLEN(32), .ADDR_W(32)) bus ();
    msrv_32_buffered_store_unit_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

    msrv_32_buffered_store_unit #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
        .funct3_in(f3), .iaddr_in(addr), .rs2_in(rs2), .mem_wr_req_in(req),
        .st_ready_out(st_ready), .misaligned_out(mis), .ld_addr_in(ld_addr),
        .ld_hazard_out(hz), .count_out(count), .bus(bus));

    msrv_32_buffered_store_unit #(.XLEN(64), .DEPTH(DEPTH), .ADDR_W(32)) dut64 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
        .funct3_in(f3_64), .iaddr_in(addr_64), .rs2_in(rs2_64), .mem_wr_req_in(req_64),
        .st_ready_out(st_ready_64), .misaligned_out(mis_64), .ld_addr_in(ld_addr_64),
        .ld_hazard_out(hz_64), .count_out(count_64), .bus(bus64));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending stores plus the bus phase (0 idle, 1 addr, 2 data)
    typedef struct { logic [31:0] a; logic [3:0] m; logic [31:0] d; } ent_t;
    ent_t q[$];
    int   ph = 0;
    bit   last_push = 0;

    function automatic bit m_mis(input logic [1:0] f, input logic [31:0] a);
        case (f)
            2'd0: return 1'b0;
            2'd1: return a[0];
            2'd2: return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic ent_t m_ent(input logic [1:0] f, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        int size;
        longint dl;
        size = 1 << f;
        e.a  = a & ~32'h3;
        e.m  = 4'((((1 << size) - 1) << a[1:0]) & 15);
        dl   = longint'(d) & ((64'h1 << (8 * size)) - 1);
        e.d  = '0;
        for (int i = 0; i < 4 / size; i++) e.d = e.d | 32'(dl << (8 * size * i));
        return e;
    endfunction

    function automatic bit exp_hz();
        for (int i = 0; i < q.size(); i++)
            if (q[i].a[31:2] == ld_addr[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        chk("count", count, q.size());
        chk("st_ready", st_ready, q.size() < DEPTH);
        chk("htrans", bus.ahb_htrans_out, (ph == 1) ? 2 : 0);
        chk("wr_req", bus.ms_riscv32_mp_dmwr_req_out, ph == 1);
        chk("hazard", hz, exp_hz());
        if (ph == 0) begin
            chk("idle_addr", bus.ms_riscv32_mp_dmaddr_out, 0);
            chk("idle_mask", bus.ms_riscv32_mp_dmwr_mask_out, 0);
            chk("idle_data", bus.ms_riscv32_mp_dmdata_out, 0);
        end else if (q.size() == 0) begin
            chk("model_nonempty", 0, 1);
        end else if (ph == 1) begin
            chk("head_addr", bus.ms_riscv32_mp_dmaddr_out, q[0].a);
            chk("head_mask", bus.ms_riscv32_mp_dmwr_mask_out, q[0].m);
        end else begin
            chk("head_data", bus.ms_riscv32_mp_dmdata_out, q[0].d);
        end
    endtask

    task automatic tick();
        bit   push, pop;
        ent_t e;
        push = rst_n && req && !m_mis(f3, addr) && (q.size() < DEPTH);
        pop  = rst_n && (ph == 2) && bus.ahb_ready_in;
        e    = m_ent(f3, addr, rs2);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            ph = 0;
            last_push = 0;
        end else begin
            if (pop) q.delete(0);
            if (push) q.push_back(e);
            case (ph)
                0: if (q.size() != 0) ph = 1;
                1: if (pop || bus.ahb_ready_in) ph = 2;
                default: if (pop) ph = (q.size() != 0) ? 1 : 0;
            endcase
            last_push = push;
        end
        check_outputs();
    endtask

    task automatic drive(input bit r, input logic [1:0] f, input logic [31:0] a, input logic [31:0] d);
        req = r; f3 = f; addr = a; rs2 = d;
        #1;
        chk("misaligned", mis, r && m_mis(f, a));
        chk("hazard_comb", hz, exp_hz());
    endtask

    typedef struct {
        logic [1:0] f; logic [31:0] a; logic [31:0] d;
        bit em; logic [31:0] ea; logic [3:0] mk; logic [31:0] ed;
    } vec_t;
    vec_t vt[7];
    logic [31:0] seen[$];
    int k;

    initial begin
        vt[0] = '{2'd0, 32'h10000003, 32'hABCDEF01, 1'b0, 32'h10000000, 4'b1000, 32'h01010101};
        vt[1] = '{2'd1, 32'h12345672, 32'hABCDEF01, 1'b0, 32'h12345670, 4'b1100, 32'hEF01EF01};
        vt[2] = '{2'd2, 32'h00000020, 32'hABCDEF01, 1'b0, 32'h00000020, 4'b1111, 32'hABCDEF01};
        vt[3] = '{2'd0, 32'h00000005, 32'h12345678, 1'b0, 32'h00000004, 4'b0010, 32'h78787878};
        vt[4] = '{2'd1, 32'h00000007, 32'h12345678, 1'b1, 32'h0, 4'h0, 32'h0};
        vt[5] = '{2'd2, 32'h00000001, 32'h12345678, 1'b1, 32'h0, 4'h0, 32'h0};
        vt[6] = '{2'd3, 32'h00000000, 32'h12345678, 1'b1, 32'h0, 4'h0, 32'h0};

        bus.ahb_ready_in = 1'b0;
        bus64.ahb_ready_in = 1'b1;
        #12;
        check_outputs();
        chk("rst_hazard", hz, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vector table on an empty buffer with a zero-wait bus
        bus.ahb_ready_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1, vt[i].f, vt[i].a, vt[i].d);
            chk("tbl_mis", mis, vt[i].em);
            tick();
            drive(0, 2'd0, 32'h0, 32'h0);
            if (!vt[i].em) begin
                chk("tbl_htrans", bus.ahb_htrans_out, 2'b10);
                chk("tbl_addr", bus.ms_riscv32_mp_dmaddr_out, vt[i].ea);
                chk("tbl_mask", bus.ms_riscv32_mp_dmwr_mask_out, vt[i].mk);
                tick();
                chk("tbl_data", bus.ms_riscv32_mp_dmdata_out, vt[i].ed);
                tick();
                chk("tbl_count_after", count, 0);
            end else begin
                chk("tbl_mis_count", count, 0);
                tick();
                chk("tbl_mis_htrans", bus.ahb_htrans_out, 2'b00);
            end
        end

        // XLEN=64 lane masks
        req_64 = 1; f3_64 = 2'd3; addr_64 = 32'h8; rs2_64 = 64'h1122334455667788;
        tick();
        req_64 = 0;
        chk("x64_dw_htrans", bus64.ahb_htrans_out, 2'b10);
        chk("x64_dw_addr", bus64.ms_riscv32_mp_dmaddr_out, 32'h8);
        chk("x64_dw_mask", bus64.ms_riscv32_mp_dmwr_mask_out, 8'hFF);
        tick();
        chk("x64_dw_data", bus64.ms_riscv32_mp_dmdata_out, 64'h1122334455667788);
        tick();
        req_64 = 1; f3_64 = 2'd1; addr_64 = 32'h6; rs2_64 = 64'hBEEF;
        tick();
        req_64 = 0;
        chk("x64_h_addr", bus64.ms_riscv32_mp_dmaddr_out, 32'h0);
        chk("x64_h_mask", bus64.ms_riscv32_mp_dmwr_mask_out, 8'b11000000);
        f3_64 = 2'd3; addr_64 = 32'hC; req_64 = 1; #1;
        chk("x64_dw_mis", mis_64, 1);
        req_64 = 0;
        tick(); tick();
        chk("x64_count", count_64, 0);

        // Full buffer under bus stall, then drain in order
        bus.ahb_ready_in = 1'b0;
        k = 0;
        for (int c = 0; c < 10 && k < 4; c++) begin
            drive(1, 2'd2, 32'(k * 4), 32'(k + 1));
            tick();
            if (last_push) k++;
        end
        chk("full_count", count, 4);
        chk("full_ready", st_ready, 0);
        drive(1, 2'd2, 32'h10, 32'h5);
        tick();
        chk("full_blocked_count", count, 4);
        chk("full_blocked_ready", st_ready, 0);
        bus.ahb_ready_in = 1'b1;
        seen.delete();
        for (int c = 0; c < 16; c++) begin
            if (bus.ahb_htrans_out == 2'b10) seen.push_back(bus.ms_riscv32_mp_dmaddr_out);
            tick();
            if (last_push) drive(0, 2'd0, 32'h0, 32'h0);
        end
        chk("drain_n", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("drain_order", seen[i], 32'(i * 4));
        chk("drain_empty", count, 0);

        // Load hazard against a stalled entry
        bus.ahb_ready_in = 1'b0;
        drive(1, 2'd2, 32'h40, 32'hCAFE);
        tick();
        ld_addr = 32'h42;
        drive(0, 2'd0, 32'h0, 32'h0);
        chk("hz_hit", hz, 1);
        ld_addr = 32'h44; #1;
        chk("hz_miss", hz, 0);
        ld_addr = 32'h42;
        bus.ahb_ready_in = 1'b1;
        for (int c = 0; c < 6 && q.size() != 0; c++) tick();
        #1;
        chk("hz_after_pop", hz, 0);
        ld_addr = 32'h0;

        // Reset while a transfer is in its data phase with 3 entries queued
        drive(1, 2'd2, 32'h100, 32'h1);
        tick();
        drive(1, 2'd2, 32'h104, 32'h2);
        tick();
        bus.ahb_ready_in = 1'b0;
        drive(1, 2'd2, 32'h108, 32'h3);
        tick();
        drive(0, 2'd0, 32'h0, 32'h0);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_data_phase", bus.ms_riscv32_mp_dmdata_out, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_htrans", bus.ahb_htrans_out, 2'b00);
        chk("rst_wr_req", bus.ms_riscv32_mp_dmwr_req_out, 0);
        chk("rst_count", count, 0);
        q.delete();
        ph = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_count", count, 0);
        chk("post_rst_ready", st_ready, 1);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            bus.ahb_ready_in = ($urandom_range(0, 3) != 0);
            ld_addr = 32'($urandom_range(0, 63));
            drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                  32'($urandom_range(0, 63)), $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
